// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] BUBBLE_INST_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC              = 32'd4;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// 32-bit program counter register with load enable and asynchronous reset.
module pc_reg #(
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, stall buffering and redirect handling
// against an instruction memory with variable response latency.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_FETCH | request outstanding at pc; deliver data as soon as it returns
// ST_HOLD  | fetched word parked in buffer while the pipeline is stalled
// ST_DROP  | redirected mid-request; wait out the old response, then jump
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INST = BUBBLE_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        pc_src,
    input  logic [31:0] target_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out,
    output logic        fetch_busy,
    output logic        flush_out
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next, pc_inc;
    logic         pc_load;
    logic [31:0]  buffer, buffer_next;
    logic         buffer_load;
    logic [31:0]  redir, redir_next;
    logic         redir_load;
    logic [31:0]  target;

    assign target = target_in & ~32'd3;
    assign pc_inc = pc + PC_INC;

    pc_reg #(
        .RESET_VALUE(RESET_PC)
    ) u_pc_reg (
        .clk (clk),
        .rst (rst),
        .load(pc_load),
        .d   (pc_next),
        .q   (pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_FETCH;
            buffer <= BUBBLE_INST;
            redir  <= 32'h0000_0000;
        end else begin
            state <= state_next;
            if (buffer_load) buffer <= buffer_next;
            if (redir_load)  redir  <= redir_next;
        end
    end

    always_comb begin
        state_next  = state;
        pc_load     = 1'b0;
        pc_next     = pc;
        buffer_load = 1'b0;
        buffer_next = buffer;
        redir_load  = 1'b0;
        redir_next  = redir;
        case (state)
            ST_FETCH: begin
                if (pc_src) begin
                    if (imem_ready) begin
                        pc_load = 1'b1;
                        pc_next = target;
                    end else begin
                        redir_load = 1'b1;
                        redir_next = target;
                        state_next = ST_DROP;
                    end
                end else if (imem_ready) begin
                    if (stall) begin
                        buffer_load = 1'b1;
                        buffer_next = imem_rdata;
                        state_next  = ST_HOLD;
                    end else begin
                        pc_load = 1'b1;
                        pc_next = pc_inc;
                    end
                end
            end
            ST_HOLD: begin
                if (pc_src) begin
                    pc_load     = 1'b1;
                    pc_next     = target;
                    buffer_load = 1'b1;
                    buffer_next = BUBBLE_INST;
                    state_next  = ST_FETCH;
                end else if (!stall) begin
                    pc_load    = 1'b1;
                    pc_next    = pc_inc;
                    state_next = ST_FETCH;
                end
            end
            ST_DROP: begin
                if (pc_src) begin
                    redir_load = 1'b1;
                    redir_next = target;
                end
                // A redirect arriving with the stale response is the newest one.
                if (imem_ready) begin
                    pc_load    = 1'b1;
                    pc_next    = pc_src ? target : redir;
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    always_comb begin
        imem_req     = 1'b1;
        imem_addr    = pc;
        pc_out       = pc;
        pc_plus4_out = pc_inc;
        inst_out     = BUBBLE_INST;
        fetch_busy   = 1'b0;
        flush_out    = pc_src;
        case (state)
            ST_FETCH: begin
                fetch_busy = ~imem_ready;
                if (imem_ready && !pc_src) inst_out = imem_rdata;
            end
            ST_HOLD: begin
                imem_req = 1'b0;
                inst_out = buffer;
            end
            ST_DROP: begin
                fetch_busy = 1'b1;
            end
            default: begin
                fetch_busy = 1'b1;
            end
        endcase
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter BUBBLE_INST, default 32'h0000_0000, meaning the instruction word presented when no valid fetch exists.
REQ-003 SHALL use one clock; reset is asynchronous and active-high; ports listed below, clock and reset first.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 stall  in  1  hazard unit hold request; 1 = do not advance PC.
REQ-007 pc_src  in  1  redirect taken (branch/jump resolved downstream).
REQ-008 target_in  in  32  redirect target address.
REQ-009 imem_req  out  1  instruction memory request valid.
REQ-010 imem_addr  out  32  instruction memory byte address.
REQ-011 imem_ready  in  1  memory response valid; imem_rdata is valid in the same cycle.
REQ-012 imem_rdata  in  32  instruction word.
REQ-013 inst_out  out  32  instruction to the IF/ID register.
REQ-014 pc_out  out  32  PC of inst_out.
REQ-015 pc_plus4_out  out  32  pc_out + 4.
REQ-016 fetch_busy  out  1  fetch not yet complete; drives the IF/ID hold.
REQ-017 flush_out  out  1  clears the IF/ID register (drives its clr).

Function
REQ-018 SHALL implement FSM states FETCH, HOLD, DROP; reset state FETCH.
REQ-019 FETCH: imem_req=1, imem_addr=pc; imem_addr SHALL stay stable until the cycle where imem_ready=1.
REQ-020 FETCH, imem_ready=1, pc_src=0, stall=0: inst_out=imem_rdata, pc_out=pc; next pc=pc+4; stay FETCH.
REQ-021 FETCH, imem_ready=1, pc_src=0, stall=1: capture imem_rdata into buffer; pc unchanged; go HOLD.
REQ-022 FETCH, imem_ready=0, pc_src=0: fetch_busy=1, inst_out=BUBBLE_INST; stay FETCH.
REQ-023 FETCH, pc_src=1, imem_ready=1: discard data; pc<=target_in; flush_out=1; stay FETCH.
REQ-024 FETCH, pc_src=1, imem_ready=0: latch target_in into redirect register; flush_out=1; go DROP.
REQ-025 DROP: imem_req=1 on the old address; fetch_busy=1; inst_out=BUBBLE_INST; on imem_ready discard data, pc<=redirect register, go FETCH.
REQ-026 DROP, pc_src=1 again: overwrite the redirect register with target_in; flush_out=1.
REQ-027 HOLD: imem_req=0; inst_out=buffer, pc_out=pc; stall=0 -> pc<=pc+4, go FETCH.
REQ-028 HOLD, pc_src=1: pc<=target_in; flush_out=1; buffer invalidated; go FETCH.
REQ-029 Priority SHALL be pc_src over stall over normal advance.
REQ-030 pc_plus4_out SHALL equal pc_out+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
REQ-031 flush_out SHALL be combinational from pc_src; all other outputs derive from registers plus imem inputs; no combinational path from stall to imem_addr.
REQ-032 target_in[1:0] SHALL be ignored (forced to 0).

Reset
REQ-033 On rst: pc=RESET_PC, state=FETCH, buffer=BUBBLE_INST, redirect register=0; after reset imem_req=1 and imem_addr=RESET_PC.
REQ-034 Reset during DROP or HOLD SHALL abandon the pending request; no discard bookkeeping survives reset.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, BUBBLE_INST default, and the constant 32'd4.
REQ-036 One sub-module pc_reg SHALL implement the 32-bit async-reset PC register with load enable.

Verification
REQ-037 Reset, imem_ready=1 always -> imem_addr 0x0, 0x4, 0x8 on consecutive cycles; pc_plus4_out 0x4, 0x8, 0xC.
REQ-038 imem_ready low for 3 cycles at pc=0x10 -> fetch_busy=1 for 3 cycles; inst_out=BUBBLE_INST; then inst at 0x10, next addr 0x14.
REQ-039 stall=1 for 2 cycles at pc=0x20 with rdata 0xDEADBEEF -> inst_out holds 0xDEADBEEF; imem_req=0; after release addr 0x24.
REQ-040 pc_src=1, target 0x100, while waiting at 0x40 -> flush_out=1; 0x40 data discarded; next imem_addr=0x100.
REQ-041 pc_src=1 and stall=1 in the same cycle, target 0x200 -> redirect wins; next imem_addr=0x200.
REQ-042 rst asserted mid-DROP -> imem_addr=RESET_PC immediately (asynchronous); the old target is never fetched.
